rambus_sample_reader: RTL and testbench

//  Wishbone classic initiator driving the rambus master port into the OpenRAM wrapper's port B.

---
 rtl/rambus_sample_reader.sv | 202 ++++++++++++++++++++
 tb/tb_rambus_sample_reader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_sample_reader.sv
// rambus_sample_reader
//   Wishbone classic initiator on the rambus master port (OpenRAM wrapper
//   port B). Streams an inclusive word range out of the 1kB RAM, once or
//   looping. Fetched words land in a small first-word-fall-through FIFO
//   that feeds a valid/ready sample stream.
//
// Ports
//   wb_clk_i, wb_rst_n_i       clock, asynchronous active-low reset
//   enable_i, loop_i           run request (level), wrap at range end
//   start_word_i, end_word_i   inclusive word range (byte addr = index*4)
//   sample_valid_o/data_o      FIFO head; popped on valid & sample_ready_i
//   done_o, err_o              non-loop range fetched / ack timeout
//   rambus_wb_*                Wishbone master towards the RAM wrapper
module rambus_sample_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        enable_i,
    input  logic        loop_i,
    input  logic [7:0]  start_word_i,
    input  logic [7:0]  end_word_i,
    output logic        sample_valid_o,
    output logic [31:0] sample_data_o,
    input  logic        sample_ready_i,
    output logic        done_o,
    output logic        err_o,
    output logic        rambus_wb_clk_o,
    output logic        rambus_wb_rst_o,
    output logic        rambus_wb_stb_o,
    output logic        rambus_wb_cyc_o,
    output logic        rambus_wb_we_o,
    output logic [3:0]  rambus_wb_sel_o,
    output logic [31:0] rambus_wb_dat_o,
    output logic [9:0]  rambus_wb_adr_o,
    input  logic        rambus_wb_ack_i,
    input  logic [31:0] rambus_wb_dat_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [7:0]  ptr_q;
    logic [7:0]  timer_q;
    logic        stb_q;
    logic        done_q;
    logic        err_q;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    logic ack_take;
    logic push;
    logic pop;
    logic flush;
    logic fifo_valid;

    // A word acked after enable_i has dropped is discarded together with
    // the rest of the FIFO, so push and flush are never both set.
    always_comb begin
        fifo_valid = (cnt_q != '0);
        ack_take   = (state_q == S_REQ) && rambus_wb_ack_i;
        push       = ack_take && enable_i;
        flush      = ((state_q == S_IDLE) && enable_i)
                   || (((state_q == S_WAIT) || (state_q == S_DONE) || (state_q == S_ERR)) && !enable_i)
                   || (ack_take && !enable_i);
        pop        = fifo_valid && sample_ready_i && !flush;
    end

    // Control FSM. stb_q is set on entry to REQ and cleared on exit, so
    // an ack at cycle N passes through WAIT and the next strobe is N+2.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            timer_q <= '0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        ptr_q   <= start_word_i;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q < DEPTH_C) begin
                        stb_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rambus_wb_ack_i) begin
                        stb_q   <= 1'b0;
                        timer_q <= '0;
                        if (!enable_i) begin
                            state_q <= S_IDLE;
                        end else if (ptr_q == end_word_i) begin
                            if (loop_i) begin
                                ptr_q   <= start_word_i;
                                state_q <= S_WAIT;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            ptr_q   <= ptr_q + 8'd1;
                            state_q <= S_WAIT;
                        end
                    end else if (timer_q == TMO_LAST) begin
                        stb_q   <= 1'b0;
                        timer_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (!enable_i) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (!enable_i) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    stb_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage needs no reset: the head is masked while empty.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_q] <= rambus_wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign sample_valid_o  = fifo_valid;
    assign sample_data_o   = fifo_valid ? mem_q[rd_q] : '0;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_n_i;
    assign rambus_wb_stb_o = stb_q;
    assign rambus_wb_cyc_o = stb_q;
    assign rambus_wb_we_o  = 1'b0;
    assign rambus_wb_sel_o = 4'hF;
    assign rambus_wb_dat_o = '0;
    assign rambus_wb_adr_o = {ptr_q, 2'b00};

endmodule

// File: tb/tb_rambus_sample_reader.sv
// tb_rambus_sample_reader
//   Drives rambus_sample_reader against a Wishbone responder with
//   configurable ack latency and a transaction-level model of the word
//   stream (expected address order, queued samples, done/err mode).
module tb_rambus_sample_reader;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        loop_w = 1'b0;
    logic [7:0]  start_w = '0;
    logic [7:0]  end_w = '0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] data;
    logic        done;
    logic        err;
    logic        rb_clk;
    logic        rb_rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [9:0]  adr;
    logic        ack;
    logic [31:0] dat_i;

    always #5 clk = ~clk;

    rambus_sample_reader #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (rst_n),
        .enable_i        (en),
        .loop_i          (loop_w),
        .start_word_i    (start_w),
        .end_word_i      (end_w),
        .sample_valid_o  (valid),
        .sample_data_o   (data),
        .sample_ready_i  (ready),
        .done_o          (done),
        .err_o           (err),
        .rambus_wb_clk_o (rb_clk),
        .rambus_wb_rst_o (rb_rst),
        .rambus_wb_stb_o (stb),
        .rambus_wb_cyc_o (cyc),
        .rambus_wb_we_o  (we),
        .rambus_wb_sel_o (sel),
        .rambus_wb_dat_o (dat_o),
        .rambus_wb_adr_o (adr),
        .rambus_wb_ack_i (ack),
        .rambus_wb_dat_i (dat_i)
    );

    // Responder: RAM contents carry the word index in the low byte.
    logic [31:0] ram [256];
    int          lat = 0;
    bit          noack = 1'b0;
    int          wcnt;

    assign ack   = stb && !noack && (wcnt == lat);
    assign dat_i = ram[adr[9:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          wcnt <= 0;
        else if (stb && !ack) wcnt <= wcnt + 1;
        else                 wcnt <= 0;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model and per-cycle compare, sampled on the falling edge.
    typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mmode_t;
    mmode_t      mode = M_IDLE;
    logic [31:0] q[$];
    int          exp_ptr = 0;
    int          run = 0;
    bit          prev_term = 1'b0;
    bit          prev_stb = 1'b0;
    logic [9:0]  prev_adr = '0;
    logic [9:0]  ack_log[$];
    logic [7:0]  pop_log[$];
    int          dut_run = 0;
    int          stb_len = 0;
    bit          done_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_stb", stb, 0);
            chk("rst_cyc", cyc, 0);
            chk("rst_valid", valid, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_data", data, 0);
            chk("rst_adr", adr, 0);
            chk("rst_rbrst", rb_rst, 1);
            mode = M_IDLE;
            q.delete();
            run = 0;
            prev_term = 1'b0;
            prev_stb = 1'b0;
            dut_run = 0;
        end else begin
            if (done) done_seen = 1'b1;
            if (stb) dut_run++;
            else if (dut_run != 0) begin
                stb_len = dut_run;
                dut_run = 0;
            end
            chk("cyc_eq_stb", cyc, stb);
            chk("valid", valid, q.size() != 0);
            if (q.size() != 0) chk("data", data, q[0]);
            chk("done", done, mode == M_DONE);
            chk("err", err, mode == M_ERR);
            chk("rbrst", rb_rst, 0);
            if (prev_term) chk("stb_gap", stb, 0);
            if (stb && prev_stb && !prev_term) chk("adr_stable", adr, prev_adr);
            if (stb && !prev_stb) begin
                chk("issue_room", q.size() < DEPTH, 1);
                chk("issue_mode", mode == M_RUN, 1);
            end
            if (ready && q.size() != 0) begin
                pop_log.push_back(data[7:0]);
                void'(q.pop_front());
            end
            prev_term = 1'b0;
            case (mode)
                M_IDLE: begin
                    if (en) begin
                        q.delete();
                        exp_ptr = int'(start_w);
                        mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (stb) begin
                        run++;
                        if (ack) begin
                            chk("adr", adr, {exp_ptr[7:0], 2'b00});
                            ack_log.push_back(adr);
                            prev_term = 1'b1;
                            run = 0;
                            if (!en) begin
                                q.delete();
                                mode = M_IDLE;
                            end else begin
                                q.push_back(ram[exp_ptr]);
                                if (exp_ptr == int'(end_w)) begin
                                    if (loop_w) exp_ptr = int'(start_w);
                                    else        mode = M_DONE;
                                end else begin
                                    exp_ptr = (exp_ptr + 1) % 256;
                                end
                            end
                        end else if (run == TMO) begin
                            prev_term = 1'b1;
                            run = 0;
                            mode = M_ERR;
                        end
                    end else if (!en) begin
                        q.delete();
                        mode = M_IDLE;
                    end
                end
                default: begin
                    if (!en) begin
                        q.delete();
                        mode = M_IDLE;
                    end
                end
            endcase
            prev_stb = stb;
            prev_adr = adr;
        end
    end

    bit rand_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_bus();
        for (int k = 0; k < 300 && stb; k++) step(1);
        chk("bus_idle", stb, 0);
    endtask

    logic [31:0] tmp;
    logic [9:0]  t1_adr [4];
    logic [7:0]  t3_words [5];

    initial begin
        t1_adr   = '{10'h008, 10'h00C, 10'h010, 10'h014};
        t3_words = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd254};
        for (int i = 0; i < 256; i++) begin
            tmp = $urandom();
            ram[i] = {tmp[31:8], 8'(i)};
        end

        step(3);
        chk("tie_we", we, 0);
        chk("tie_sel", sel, 4'hF);
        chk("tie_dat", dat_o, 0);
        chk("tie_clk", rb_clk, clk);
        rst_n = 1'b1;
        step(2);

        // Single pass 2..5, zero-wait responder.
        start_w = 8'd2; end_w = 8'd5; loop_w = 1'b0; ready = 1'b1; lat = 0;
        ack_log.delete(); pop_log.delete();
        en = 1'b1;
        for (int k = 0; k < 100 && !done; k++) step(1);
        chk("t1_done", done, 1);
        step(20);
        chk("t1_nacks", ack_log.size(), 4);
        chk("t1_npops", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("t1_adr", ack_log[i], t1_adr[i]);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("t1_word", pop_log[i], 8'(i + 2));
        chk("t1_stb_quiet", stb, 0);
        en = 1'b0;
        step(3);
        chk("t1_done_clr", done, 0);

        // Back-pressure: FIFO fills and fetching halts.
        start_w = 8'd0; end_w = 8'd15; ready = 1'b0;
        ack_log.delete(); pop_log.delete();
        en = 1'b1;
        step(60);
        chk("t2_nacks_full", ack_log.size(), 4);
        chk("t2_cyc_idle", cyc, 0);
        chk("t2_valid", valid, 1);
        ready = 1'b1;
        for (int k = 0; k < 400 && !done; k++) step(1);
        chk("t2_done", done, 1);
        step(3);
        chk("t2_npops", pop_log.size(), 16);
        for (int i = 0; i < 16 && i < pop_log.size(); i++) chk("t2_word", pop_log[i], 8'(i));
        en = 1'b0;
        step(3);

        // Looping across the 255->0 wrap.
        start_w = 8'd254; end_w = 8'd1; loop_w = 1'b1;
        pop_log.delete(); done_seen = 1'b0;
        en = 1'b1;
        step(40);
        en = 1'b0;
        wait_idle_bus();
        step(3);
        chk("t3_npops", pop_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) chk("t3_word", pop_log[i], t3_words[i]);
        chk("t3_no_done", done_seen, 0);
        loop_w = 1'b0;

        // Responder never acks.
        noack = 1'b1; start_w = 8'd3; end_w = 8'd9;
        en = 1'b1;
        for (int k = 0; k < 400 && !err; k++) step(1);
        step(2);
        chk("t4_err", err, 1);
        chk("t4_stb_len", stb_len, 255);
        chk("t4_stb_low", stb, 0);
        en = 1'b0;
        step(2);
        chk("t4_err_clr", err, 0);
        noack = 1'b0;

        // Enable drops mid-transfer with 3-cycle ack latency.
        lat = 3; start_w = 8'd10; end_w = 8'd20; ready = 1'b0;
        ack_log.delete();
        en = 1'b1;
        for (int k = 0; k < 100 && !(ack_log.size() == 2 && stb); k++) step(1);
        chk("t5_in_req", stb, 1);
        chk("t5_pre_valid", valid, 1);
        en = 1'b0;
        wait_idle_bus();
        step(2);
        chk("t5_acks", ack_log.size(), 3);
        chk("t5_valid", valid, 0);
        chk("t5_err", err, 0);
        step(2);

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            lat = $urandom_range(0, 3);
            start_w = 8'($urandom_range(0, 255));
            end_w = 8'(int'(start_w) + $urandom_range(0, 12));
            if (it == 5) end_w = start_w;
            loop_w = 1'($urandom_range(0, 1));
            rand_ready = 1'b1;
            en = 1'b1;
            step($urandom_range(40, 150));
            if (it % 3 == 1) begin
                en = 1'b0;
                step(1);
                en = 1'b1;
                step(50);
            end
            en = 1'b0;
            wait_idle_bus();
            rand_ready = 1'b0;
            step(2);
        end
        ready = 1'b0;

        // Asynchronous reset in the middle of a transfer.
        lat = 3; start_w = 8'd0; end_w = 8'd7;
        ack_log.delete();
        en = 1'b1;
        for (int k = 0; k < 100 && !(ack_log.size() == 2 && stb); k++) step(1);
        chk("t6_pre_stb", stb, 1);
        chk("t6_pre_valid", valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_stb", stb, 0);
        chk("t6_cyc", cyc, 0);
        chk("t6_valid", valid, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_rbrst", rb_rst, 1);
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
